// File: rtl/out_check_pkg.sv
// Shared types and default sizing for the out-channel checker.
// Configuration macro: OUT_CHECKER_CAPTURE_EN (see out_channel_checker).
package out_check_pkg;

    // Checker run phases
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } checkState_t;

    localparam int DEF_MEM_WIDTH   = 12;
    localparam int DEF_N_EXPECTED  = 32;
    localparam int DEF_FIFO_DEPTH  = 8;
    localparam int DEF_INDEX_WIDTH = $clog2(DEF_N_EXPECTED) + 1;

    // first_bad value meaning "no mismatch seen" at the default index width
    localparam logic [DEF_INDEX_WIDTH-1:0] NO_MISMATCH = '1;

endpackage

// File: rtl/out_channel_checker_fifo.sv
// Purpose: generic synchronous FIFO buffering out-channel words ahead of the comparator.
// Latency: first-word fall-through; a pushed word is visible on popDat the next cycle.
// Backpressure: full blocks pushes unless a pop happens in the same cycle; pops ignored when empty.
module out_fifo #(
    parameter int Width = 12,
    parameter int Depth = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             push,
    input  logic [Width-1:0] pushDat,
    input  logic             pop,
    output logic [Width-1:0] popDat,
    output logic             full,
    output logic             empty
);

    localparam int PtrWidth = $clog2(Depth);

    // Extra MSB on each pointer is the wrap bit that separates full from empty
    logic [PtrWidth:0] wrPtr;
    logic [PtrWidth:0] rdPtr;
    logic [Width-1:0]  mem [Depth];
    logic              doPush;
    logic              doPop;

    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[PtrWidth] != rdPtr[PtrWidth]) &&
                    (wrPtr[PtrWidth-1:0] == rdPtr[PtrWidth-1:0]);
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign popDat = mem[rdPtr[PtrWidth-1:0]];

    // Pointer update; a flush returns both pointers to zero
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else if (clr) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility
    always_ff @(posedge clock) begin
        if (doPush) mem[wrPtr[PtrWidth-1:0]] <= pushDat;
    end

endmodule

// File: rtl/out_channel_checker.sv
// Purpose: buffers out-channel words and checks them in order against a loadable expected table.
// Latency: push to FIFO, pop next cycle, compare one cycle after pop (registered table read).
// Backpressure: out_ready only in RUN and only while the FIFO has room (or pops the same cycle).
// Optional build macro OUT_CHECKER_CAPTURE_EN adds a capture memory with cap_addr/cap_data ports.
module out_channel_checker
    import out_check_pkg::*;
#(
    parameter int MemoryElementWidth = DEF_MEM_WIDTH,
    parameter int NExpected          = DEF_N_EXPECTED,
    parameter int FifoDepth          = DEF_FIFO_DEPTH,
    parameter int IndexWidth         = $clog2(NExpected) + 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          out_valid,
    output logic                          out_ready,
    input  logic [MemoryElementWidth-1:0] out_data,
    input  logic                          halt,
    input  logic                          exp_we,
    input  logic [IndexWidth-2:0]         exp_addr,
    input  logic [MemoryElementWidth-1:0] exp_data,
    input  logic [IndexWidth-1:0]         exp_count,
    input  logic                          start,
`ifdef OUT_CHECKER_CAPTURE_EN
    input  logic [IndexWidth-2:0]         cap_addr,
    output logic [MemoryElementWidth-1:0] cap_data,
`endif
    output logic                          finished,
    output logic                          success,
    output logic [IndexWidth-1:0]         received,
    output logic [IndexWidth-1:0]         first_bad,
    output logic                          overflow
);

    localparam int                    AddrWidth  = IndexWidth - 1;
    localparam logic [IndexWidth-1:0] noMismatch = '1;
    localparam logic [IndexWidth-1:0] nExpIdx    = IndexWidth'(NExpected);

    checkState_t                   state;
    checkState_t                   nextState;

    logic                          push;
    logic                          pop;
    logic                          fifoFull;
    logic                          fifoEmpty;
    logic [MemoryElementWidth-1:0] fifoDat;

    logic [MemoryElementWidth-1:0] expTable [NExpected];
    logic [MemoryElementWidth-1:0] expRd;
    logic                          tableWe;

    logic [IndexWidth-1:0]         countLatched;
    logic [IndexWidth-1:0]         popIdx;
    logic                          popInRange;
    logic                          popOver;

    logic                          cmpVld;
    logic                          cmpInRange;
    logic                          cmpOver;
    logic [MemoryElementWidth-1:0] cmpDat;
    logic [IndexWidth-1:0]         cmpIdx;

    logic                          runStart;
    logic                          retired;

    // A run may only be launched from IDLE or DONE; start is a no-op elsewhere
    assign runStart   = start && ((state == IDLE) || (state == DONE));
    // Nothing left in flight: FIFO empty and compare stage idle
    assign retired    = fifoEmpty && !cmpVld;
    assign push       = out_valid && out_ready;
    assign tableWe    = exp_we && (state == IDLE) && ({1'b0, exp_addr} < nExpIdx);
    // Words past the latched count are overflow and skip the table read
    assign popInRange = (popIdx < countLatched) && (popIdx < nExpIdx);
    assign popOver    = (popIdx >= countLatched);

    out_fifo #(
        .Width (MemoryElementWidth),
        .Depth (FifoDepth)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .clr     (runStart),
        .push    (push),
        .pushDat (out_data),
        .pop     (pop),
        .popDat  (fifoDat),
        .full    (fifoFull),
        .empty   (fifoEmpty)
    );

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // FSM next-state logic
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (start)   nextState = RUN;
            RUN:     if (halt)    nextState = DRAIN;
            DRAIN:   if (retired) nextState = DONE;
            DONE:    if (start)   nextState = RUN;
            default:              nextState = IDLE;
        endcase
    end

    // FSM outputs: drain one word per cycle while running or draining, accept only in RUN
    always_comb begin
        pop       = 1'b0;
        out_ready = 1'b0;
        unique case (state)
            RUN: begin
                pop       = !fifoEmpty;
                out_ready = !fifoFull || !fifoEmpty;
            end
            DRAIN: begin
                pop       = !fifoEmpty;
            end
            default: begin
                pop       = 1'b0;
                out_ready = 1'b0;
            end
        endcase
    end

    // Expected table: written only in IDLE, read once per popped in-range word; never reset
    always_ff @(posedge clock) begin
        if (tableWe) expTable[exp_addr] <= exp_data;
        if (pop && popInRange) expRd <= expTable[popIdx[AddrWidth-1:0]];
    end

    // Pop stage: capture the popped word and its index for the compare stage
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            countLatched <= '0;
            popIdx       <= '0;
            cmpVld       <= 1'b0;
            cmpInRange   <= 1'b0;
            cmpOver      <= 1'b0;
            cmpDat       <= '0;
            cmpIdx       <= '0;
        end else if (runStart) begin
            countLatched <= exp_count;
            popIdx       <= '0;
            cmpVld       <= 1'b0;
            cmpInRange   <= 1'b0;
            cmpOver      <= 1'b0;
        end else begin
            cmpVld <= pop;
            if (pop) begin
                cmpDat     <= fifoDat;
                cmpIdx     <= popIdx;
                cmpInRange <= popInRange;
                cmpOver    <= popOver;
                if (popIdx != nExpIdx) popIdx <= popIdx + 1'b1;
            end
        end
    end

    // Compare stage: record the first mismatch, flag overflow, count compared words
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            received  <= '0;
            first_bad <= noMismatch;
            overflow  <= 1'b0;
        end else if (runStart) begin
            received  <= '0;
            first_bad <= noMismatch;
            overflow  <= 1'b0;
        end else if (cmpVld) begin
            if (cmpInRange && (cmpDat != expRd) && (first_bad == noMismatch))
                first_bad <= cmpIdx;
            if (cmpOver) overflow <= 1'b1;
            if (received != nExpIdx) received <= received + 1'b1;
        end
    end

    // Verdict: evaluated once, on the DRAIN->DONE step, after the last compare retired
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            finished <= 1'b0;
            success  <= 1'b0;
        end else if (runStart) begin
            finished <= 1'b0;
            success  <= 1'b0;
        end else if ((state == DRAIN) && retired) begin
            finished <= 1'b1;
            success  <= (first_bad == noMismatch) && !overflow && (received == countLatched);
        end
    end

`ifdef OUT_CHECKER_CAPTURE_EN
    logic [MemoryElementWidth-1:0] capMem [NExpected];

    // Capture every compared word at its index; saturated indices are dropped
    always_ff @(posedge clock) begin
        if (cmpVld && (cmpIdx < nExpIdx)) capMem[cmpIdx[AddrWidth-1:0]] <= cmpDat;
    end

    assign cap_data = capMem[cap_addr];
`endif

endmodule

// File: tb/tb_out_channel_checker.sv
module tb_out_channel_checker;
    import out_check_pkg::*;

    localparam int W  = 12;
    localparam int NE = 32;
    localparam int IW = 6;
    localparam int NONE = 63;

    logic          clock = 1'b0;
    logic          reset;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          halt;
    logic          exp_we;
    logic [IW-2:0] exp_addr;
    logic [W-1:0]  exp_data;
    logic [IW-1:0] exp_count;
    logic          start;
    logic          finished;
    logic          success;
    logic [IW-1:0] received;
    logic [IW-1:0] first_bad;
    logic          overflow;

    always #5 clock = ~clock;

    out_channel_checker #(
        .MemoryElementWidth (W),
        .NExpected          (NE),
        .FifoDepth          (4),
        .IndexWidth         (IW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .halt      (halt),
        .exp_we    (exp_we),
        .exp_addr  (exp_addr),
        .exp_data  (exp_data),
        .exp_count (exp_count),
        .start     (start),
        .finished  (finished),
        .success   (success),
        .received  (received),
        .first_bad (first_bad),
        .overflow  (overflow)
    );

    typedef struct {
        int       count;
        int       nWords;
        int       badIdx;
        logic [W-1:0] badVal;
        bit       haltWithLast;
        bit       exSuccess;
        int       exReceived;
        int       exFirstBad;
        bit       exOverflow;
    } vec_t;

    vec_t         vecs [6];
    logic [W-1:0] tableVals [10];
    int           checks = 0;
    int           passed = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, " out_ready"}, int'(out_ready), 0);
        check({tag, " finished"},  int'(finished),  0);
        check({tag, " success"},   int'(success),   0);
        check({tag, " received"},  int'(received),  0);
        check({tag, " first_bad"}, int'(first_bad), NONE);
        check({tag, " overflow"},  int'(overflow),  0);
    endtask

    task automatic pulseStart(input int count);
        exp_count = IW'(count);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic runVec(input vec_t v, input int id);
        int stalls;
        int tries;
        stalls = 0;
        pulseStart(v.count);
        @(negedge clock);
        check($sformatf("v%0d finished cleared", id), int'(finished), 0);
        @(posedge clock); #1;
        for (int k = 0; k < v.nWords; k++) begin
            out_valid = 1'b1;
            out_data  = (k == v.badIdx) ? v.badVal : tableVals[k];
            halt      = v.haltWithLast && (k == v.nWords - 1);
            @(negedge clock);
            tries = 0;
            while (!out_ready && tries < 20) begin
                stalls++;
                tries++;
                @(negedge clock);
            end
            @(posedge clock); #1;
        end
        out_valid = 1'b0;
        halt      = 1'b0;
        if (!v.haltWithLast) begin
            halt = 1'b1;
            @(posedge clock); #1;
            halt = 1'b0;
        end
        tries = 0;
        @(negedge clock);
        while (!finished && tries < 100) begin
            tries++;
            @(negedge clock);
        end
        check($sformatf("v%0d finished", id),  int'(finished),  1);
        check($sformatf("v%0d success", id),   int'(success),   int'(v.exSuccess));
        check($sformatf("v%0d received", id),  int'(received),  v.exReceived);
        check($sformatf("v%0d first_bad", id), int'(first_bad), v.exFirstBad);
        check($sformatf("v%0d overflow", id),  int'(overflow),  int'(v.exOverflow));
        check($sformatf("v%0d stall cycles", id), stalls, 0);
        @(posedge clock); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        halt      = 1'b0;
        exp_we    = 1'b0;
        exp_addr  = '0;
        exp_data  = '0;
        exp_count = '0;
        start     = 1'b0;

        tableVals = '{12'd1, 12'd3, 12'd5, 12'd9, 12'd10, 12'd2, 12'd4, 12'd7, 12'd6, 12'd11};
        //            count nW bad badVal hwl  succ recv fbad ovf
        vecs[0] = '{7,  7,  -1, 12'd0, 1'b0, 1'b1, 7,  NONE, 1'b0};  // clean pass
        vecs[1] = '{7,  7,   3, 12'd8, 1'b0, 1'b0, 7,  3,    1'b0};  // 4th word wrong
        vecs[2] = '{3,  5,  -1, 12'd0, 1'b0, 1'b0, 5,  NONE, 1'b1};  // too many words
        vecs[3] = '{5,  3,  -1, 12'd0, 1'b0, 1'b0, 3,  NONE, 1'b0};  // short run
        vecs[4] = '{10, 10, -1, 12'd0, 1'b1, 1'b1, 10, NONE, 1'b0};  // streaming, halt on last word
        vecs[5] = '{0,  0,  -1, 12'd0, 1'b0, 1'b1, 0,  NONE, 1'b0};  // empty program

        repeat (3) @(posedge clock);
        @(negedge clock);
        checkResetValues("reset");
        @(posedge clock); #1;
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            exp_we   = 1'b1;
            exp_addr = (IW-1)'(i);
            exp_data = tableVals[i];
            @(posedge clock); #1;
        end
        exp_we = 1'b0;

        for (int i = 0; i < 6; i++) runVec(vecs[i], i);

        // Reset in the middle of a run after two accepted words
        pulseStart(7);
        for (int k = 0; k < 2; k++) begin
            out_valid = 1'b1;
            out_data  = tableVals[k];
            @(posedge clock); #1;
        end
        out_valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        checkResetValues("midrun reset");
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        // Table must have survived the reset
        runVec(vecs[0], 6);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/out_channel_checker.md
Name: out_channel_checker

Overview:
- Downstream consumer of the program-execution core's out channel. Each `out` instruction emits one word here instead of into a fixed outMem array.
- Buffers emitted words in a small FIFO, compares them in order against a loadable expected-value table, and raises finished/success once the program halts and the FIFO drains.
- Replaces the hard-coded per-test success chain with a reusable, table-driven checker.

Parameters:
- MemoryElementWidth, 12, width of each out-channel word and expected value
- NExpected, 32, depth of the expected-value table (max checked outputs)
- FifoDepth, 8, out-channel buffer depth; must be a power of two, at least 2
- IndexWidth, $clog2(NExpected)+1, width of counters and indices (holds 0..NExpected)

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- out_valid  in  1  core presents an out word this cycle
- out_ready  out  1  checker accepts; a transfer occurs when out_valid && out_ready
- out_data  in  MemoryElementWidth  emitted word
- halt  in  1  one-cycle pulse from the core: program reached its default/finish state
- exp_we  in  1  write enable for the expected table (honoured only in IDLE)
- exp_addr  in  IndexWidth-1  expected table write address
- exp_data  in  MemoryElementWidth  expected value
- exp_count  in  IndexWidth  number of valid expected entries; sampled on the IDLE->RUN transition
- start  in  1  one-cycle pulse: begin a checking run
- finished  out  1  high from DONE entry until the next start or reset
- success  out  1  valid while finished is high
- received  out  IndexWidth  words compared so far; saturates at NExpected
- first_bad  out  IndexWidth  index of the first mismatch; all ones if there is none
- overflow  out  1  sticky; more words were received than exp_count

Behaviour:
- Reset values (async, active-low): state=IDLE, FIFO empty, out_ready=0, finished=0, success=0, received=0, first_bad=all ones, overflow=0. The expected table is not reset.
- States and transitions:
  - IDLE -> RUN on start. RUN latches exp_count and clears received, first_bad, overflow, finished, success and the FIFO.
  - RUN -> DRAIN on halt.
  - DRAIN -> DONE when the FIFO is empty.
  - DONE -> RUN on start.
  - start is ignored in RUN and DRAIN.
- out_ready = (state==RUN) && FIFO not full. Also asserted when full if a pop happens in the same cycle.
- A push and a pop in the same cycle leave the occupancy unchanged.
- Words accepted in DRAIN or DONE are impossible because out_ready=0 there.
- Comparison pipeline: one FIFO entry is popped per cycle when non-empty. Pop-to-compare latency is 1 cycle (registered table read).
  - If received < latched count and data != table[received] and first_bad is all ones, first_bad := received.
  - If received >= latched count, overflow := 1 and no table read occurs.
  - received then increments, saturating at NExpected.
- halt in the same cycle as an accepted word: the word is still pushed, and the state moves to DRAIN.
- DONE is entered only after the final compare has retired (FIFO empty and compare stage idle).
- On entering DONE: finished := 1; success := (first_bad==all ones) && !overflow && (received==latched count).
- A short run (received < count) gives success=0 with first_bad=all ones.
- Count = 0 with no words gives success=1.
- Pointers are log2(FifoDepth) bits with an extra wrap bit. Full = same index with different wrap bit.
- Reset asserted mid-run aborts immediately to the reset values. The expected table contents are retained.

Optional Feature:
- OUT_CHECKER_CAPTURE_EN
  - Defined: adds ports cap_addr (in, IndexWidth-1) and cap_data (out, MemoryElementWidth, combinational read). Every compared word is also written to a NExpected-entry capture memory at index received (writes stop at saturation). This lets the bench dump the outMem-equivalent contents after finish.
  - Undefined: no capture memory and no cap_* ports. All other behaviour is identical.

Decomposition:
- Shared package out_check_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - localparam NO_MISMATCH (all ones of IndexWidth)
  - default width constants
- One sub-module, out_fifo: parameterised synchronous FIFO with push/pop/full/empty and the same async active-low reset.
- Table, comparator and FSM stay in the top level.

Test Plan:
- Load table {1,3,5,9,10,2,4}, count=7, start, stream those 7 words back-to-back, halt -> finished=1, success=1, received=7, first_bad=all ones, overflow=0.
- Same table, 4th word sent as 8 -> success=0, first_bad=3, received=7.
- Count=3, send 5 words -> overflow=1, received=5, success=0.
- Count=5, send 3 words, halt -> success=0, first_bad=all ones, received=3.
- FifoDepth=4, hold the compare side busy by sending 10 words in consecutive cycles with halt coincident with the last word -> out_ready drops only when full, no word lost, the last word is checked, and DONE follows the final compare.
- Assert reset mid-RUN after 2 words, release, start a new run with the table intact -> all outputs return to reset values; the second run passes with the original table.
